// File: rtl/unsat_clause_selector_if.sv
// Controller-facing port bundle of unsat_clause_selector: clause results in, selections out.
// master = controller side, slave = the selector itself.
interface unsat_clause_selector_if #(
    parameter int unsigned CLAUSE_ID_WIDTH = 16,
    parameter int unsigned DEPTH           = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                       epoch_start_i;
    logic                       wr_en_i;
    logic                       unsat_i;
    logic [CLAUSE_ID_WIDTH-1:0] clause_id_i;
    logic                       req_i;
    logic                       sel_valid_o;
    logic [CLAUSE_ID_WIDTH-1:0] sel_clause_id_o;
    logic                       all_sat_o;
    logic                       busy_o;
    logic                       overflow_o;
    logic [ADDR_W:0]            count_o;

    modport master (
        output epoch_start_i, wr_en_i, unsat_i, clause_id_i, req_i,
        input  sel_valid_o, sel_clause_id_o, all_sat_o, busy_o, overflow_o, count_o
    );

    modport slave (
        input  epoch_start_i, wr_en_i, unsat_i, clause_id_i, req_i,
        output sel_valid_o, sel_clause_id_o, all_sat_o, busy_o, overflow_o, count_o
    );
endinterface

// File: rtl/unsat_clause_selector.sv
// Buffers unsatisfied clause indices per epoch and returns one per request.
// Define SELECTOR_RANDOM_EN to seed the pick from the LFSR; otherwise a round-robin pointer is used.
module unsat_clause_selector #(
    parameter int unsigned CLAUSE_ID_WIDTH = 16,
    parameter int unsigned DEPTH           = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    unsat_clause_selector_if.slave bus
);
    localparam int unsigned ADDR_W   = $clog2(DEPTH);
    localparam logic [15:0] SeedInit = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam logic [ADDR_W:0] Full = (ADDR_W+1)'(DEPTH);

    typedef enum logic {StIdle, StReduce} state_e;

    state_e                     state_q, state_d;
    logic [CLAUSE_ID_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]            count_q, count_d;
    logic [ADDR_W:0]            snap_q, snap_d;
    logic [ADDR_W-1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]          rr_q, rr_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic                       overflow_q, overflow_d;
    logic                       sel_valid_q, sel_valid_d;
    logic                       all_sat_q, all_sat_d;
    logic [CLAUSE_ID_WIDTH-1:0] sel_id_q, sel_id_d;
    logic                       unsat_wr;
    logic                       wr_accept;
    logic [ADDR_W-1:0]          wr_addr;
    logic [ADDR_W-1:0]          seed_idx;

    // Epoch start empties the buffer, so a simultaneous write lands in slot 0.
    assign unsat_wr  = bus.wr_en_i && bus.unsat_i;
    assign wr_accept = unsat_wr && (bus.epoch_start_i || (count_q != Full));
    assign wr_addr   = bus.epoch_start_i ? '0 : count_q[ADDR_W-1:0];

`ifdef SELECTOR_RANDOM_EN
    assign seed_idx = lfsr_q[ADDR_W-1:0];
`else
    assign seed_idx = rr_q;
`endif

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.epoch_start_i) begin
            count_d    = wr_accept ? (ADDR_W+1)'(1) : '0;
            overflow_d = 1'b0;
        end else if (wr_accept) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (unsat_wr) begin
            overflow_d = 1'b1;
        end
    end

    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        sel_id_d    = sel_id_q;
        sel_valid_d = 1'b0;
        all_sat_d   = 1'b0;
        if (bus.epoch_start_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_i) begin
                        if (count_q == '0) begin
                            all_sat_d = 1'b1;
                        end else begin
                            snap_d  = count_q;
                            idx_d   = seed_idx;
                            state_d = StReduce;
                        end
                    end
                end
                StReduce: begin
                    // Repeated subtraction is a cheap modulo by the snapshot count.
                    if ({1'b0, idx_q} < snap_q) begin
                        sel_id_d    = mem_q[idx_q];
                        sel_valid_d = 1'b1;
                        rr_d        = idx_q + ADDR_W'(1);
                        state_d     = StIdle;
                    end else begin
                        idx_d = idx_q - snap_q[ADDR_W-1:0];
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            count_q     <= '0;
            snap_q      <= '0;
            idx_q       <= '0;
            rr_q        <= '0;
            lfsr_q      <= SeedInit;
            overflow_q  <= 1'b0;
            sel_valid_q <= 1'b0;
            all_sat_q   <= 1'b0;
            sel_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            lfsr_q      <= lfsr_d;
            overflow_q  <= overflow_d;
            sel_valid_q <= sel_valid_d;
            all_sat_q   <= all_sat_d;
            sel_id_q    <= sel_id_d;
        end
    end

    // Storage needs no reset: slots at or above count are never read.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_addr] <= bus.clause_id_i;
        end
    end

    assign bus.sel_valid_o     = sel_valid_q;
    assign bus.sel_clause_id_o = sel_id_q;
    assign bus.all_sat_o       = all_sat_q;
    assign bus.busy_o          = (state_q == StReduce);
    assign bus.overflow_o      = overflow_q;
    assign bus.count_o         = count_q;
endmodule

// File: tb/tb_unsat_clause_selector.sv
// Self-checking bench for unsat_clause_selector against a queue-based reference model.
// Build with SELECTOR_RANDOM_EN to exercise the LFSR-seeded selection instead of round-robin.
module tb_unsat_clause_selector;
    localparam int unsigned W = 16;
    localparam int unsigned D = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    unsat_clause_selector_if #(.CLAUSE_ID_WIDTH(W), .DEPTH(D)) bus ();

    unsat_clause_selector #(
        .CLAUSE_ID_WIDTH(W),
        .DEPTH          (D),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stored ids in arrival order, sticky overflow, round-robin start.
    logic [W-1:0] m_mem[$];
    bit           m_ovf;
    int           m_rr;

    function automatic void model_epoch();
        m_mem.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_write(input logic [W-1:0] id, input bit u);
        if (u) begin
            if (m_mem.size() < D) m_mem.push_back(id);
            else m_ovf = 1'b1;
        end
    endfunction

`ifndef SELECTOR_RANDOM_EN
    // Start at rr, wrap by the number of stored entries, one cycle per wrap.
    function automatic void model_pick(input int snap, output logic [W-1:0] id, output int lat);
        int idx;
        idx  = m_rr % snap;
        lat  = 2 + m_rr / snap;
        id   = m_mem[idx];
        m_rr = (idx + 1) % D;
    endfunction
`endif

    task automatic idle_inputs();
        bus.epoch_start_i = 1'b0;
        bus.wr_en_i       = 1'b0;
        bus.unsat_i       = 1'b0;
        bus.clause_id_i   = '0;
        bus.req_i         = 1'b0;
    endtask

    task automatic write_cyc(input logic [W-1:0] id, input bit u);
        bus.wr_en_i     = 1'b1;
        bus.unsat_i     = u;
        bus.clause_id_i = id;
        model_write(id, u);
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        bus.unsat_i = 1'b0;
    endtask

    task automatic epoch_cyc();
        bus.epoch_start_i = 1'b1;
        model_epoch();
        @(negedge clk);
        bus.epoch_start_i = 1'b0;
    endtask

    task automatic drive_rand_write();
        logic [W-1:0] id;
        bit           en;
        bit           u;
        en = ($urandom_range(0, 1) == 1);
        u  = ($urandom_range(0, 3) != 0);
        id = W'($urandom());
        bus.wr_en_i     = en;
        bus.unsat_i     = u;
        bus.clause_id_i = id;
        if (en) model_write(id, u);
    endtask

    // Issue one request and wait (bounded) for sel_valid_o or all_sat_o.
    task automatic do_req(input bit with_writes, output bit got, output bit allsat,
                          output logic [W-1:0] id, output int lat, output bit busy1,
                          output bit pulse_after);
        got    = 1'b0;
        allsat = 1'b0;
        id     = '0;
        bus.req_i = 1'b1;
        if (with_writes) drive_rand_write();
        @(negedge clk);
        bus.req_i = 1'b0;
        lat   = 1;
        busy1 = bus.busy_o;
        while (lat <= int'(D) + 3) begin
            if (bus.all_sat_o) begin allsat = 1'b1; break; end
            if (bus.sel_valid_o) begin got = 1'b1; id = bus.sel_clause_id_o; break; end
            if (with_writes) drive_rand_write();
            @(negedge clk);
            lat++;
        end
        bus.wr_en_i = 1'b0;
        bus.unsat_i = 1'b0;
        @(negedge clk);
        pulse_after = bus.sel_valid_o | bus.all_sat_o;
    endtask

    task automatic test_reset();
        bit got, allsat, busy1, pa;
        logic [W-1:0] id;
        int lat;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.sel_valid_o, bus.all_sat_o, bus.busy_o, bus.overflow_o} !== 4'b0 ||
            bus.sel_clause_id_o !== '0 || int'(bus.count_o) !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got sv=%b as=%b bz=%b ov=%b id=%0d cnt=%0d required all 0",
                     bus.sel_valid_o, bus.all_sat_o, bus.busy_o, bus.overflow_o,
                     bus.sel_clause_id_o, bus.count_o);
        end
        rst_n = 1'b1;
        model_epoch();
        m_rr = 0;
        @(negedge clk);
        checks++;
        if (int'(bus.count_o) !== 0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", bus.count_o);
        end
        do_req(1'b0, got, allsat, id, lat, busy1, pa);
        checks++;
        if (!allsat || got || lat != 1 || pa || busy1) begin
            errors++;
            $display("FAIL reset_first_req: got as=%b sv=%b lat=%0d after=%b busy=%b required 1 0 1 0 0",
                     allsat, got, lat, pa, busy1);
        end
    endtask

`ifndef SELECTOR_RANDOM_EN
    task automatic test_round_robin();
        logic [W-1:0] exp_ids[4];
        int           exp_lats[4];
        bit got, allsat, busy1, pa;
        logic [W-1:0] id, mid;
        int lat, mlat;
        exp_ids  = '{16'd5, 16'd9, 16'd12, 16'd5};
        exp_lats = '{2, 2, 2, 3};
        epoch_cyc();
        write_cyc(16'd5, 1'b1);
        write_cyc(16'd7, 1'b0);
        write_cyc(16'd9, 1'b1);
        write_cyc(16'd12, 1'b1);
        checks++;
        if (int'(bus.count_o) !== 3) begin
            errors++; $display("FAIL rr_count: got %0d required 3", bus.count_o);
        end
        for (int i = 0; i < 4; i++) begin
            model_pick(3, mid, mlat);
            do_req(1'b0, got, allsat, id, lat, busy1, pa);
            checks++;
            if (!got || id !== exp_ids[i] || lat != exp_lats[i] || !busy1 || pa) begin
                errors++;
                $display("FAIL rr_req%0d: got v=%b id=%0d lat=%0d busy=%b after=%b required id=%0d lat=%0d",
                         i, got, id, lat, busy1, pa, exp_ids[i], exp_lats[i]);
            end
        end
    endtask
`endif

    task automatic test_empty();
        bit got, allsat, busy1, pa;
        logic [W-1:0] id;
        int lat;
        epoch_cyc();
        do_req(1'b0, got, allsat, id, lat, busy1, pa);
        checks++;
        if (!allsat || got || lat != 1 || pa || busy1 || bus.busy_o) begin
            errors++;
            $display("FAIL empty_req: got as=%b sv=%b lat=%0d after=%b busy=%b required 1 0 1 0 0",
                     allsat, got, lat, pa, busy1 | bus.busy_o);
        end
    endtask

    task automatic test_overflow();
        bit got, allsat, busy1, pa;
        logic [W-1:0] id, exp_id;
        int lat, exp_lat;
        epoch_cyc();
        for (int i = 0; i < 16; i++) write_cyc(W'(i), 1'b1);
        checks++;
        if (bus.overflow_o !== 1'b0 || int'(bus.count_o) !== 16) begin
            errors++;
            $display("FAIL ovf_full: got ov=%b cnt=%0d required 0 16", bus.overflow_o, bus.count_o);
        end
        write_cyc(16'd16, 1'b1);
        checks++;
        if (bus.overflow_o !== m_ovf || int'(bus.count_o) !== m_mem.size()) begin
            errors++;
            $display("FAIL ovf_drop: got ov=%b cnt=%0d required %b %0d",
                     bus.overflow_o, bus.count_o, m_ovf, m_mem.size());
        end
        for (int i = 0; i < 16; i++) begin
`ifndef SELECTOR_RANDOM_EN
            model_pick(m_mem.size(), exp_id, exp_lat);
            do_req(1'b0, got, allsat, id, lat, busy1, pa);
            checks++;
            if (!got || id !== exp_id || lat != exp_lat) begin
                errors++;
                $display("FAIL ovf_retain%0d: got v=%b id=%0d lat=%0d required id=%0d lat=%0d",
                         i, got, id, lat, exp_id, exp_lat);
            end
`else
            do_req(1'b0, got, allsat, id, lat, busy1, pa);
            checks++;
            if (!got || id > 16'd15 || lat > int'(D) + 1) begin
                errors++;
                $display("FAIL ovf_retain%0d: got v=%b id=%0d lat=%0d required id<=15 lat<=%0d",
                         i, got, id, lat, D + 1);
            end
`endif
        end
        epoch_cyc();
        checks++;
        if (bus.overflow_o !== 1'b0 || int'(bus.count_o) !== 0) begin
            errors++;
            $display("FAIL ovf_clear: got ov=%b cnt=%0d required 0 0", bus.overflow_o, bus.count_o);
        end
    endtask

    task automatic test_abort();
        bit got, allsat, busy1, pa, seen;
        logic [W-1:0] id, exp_id;
        int lat, exp_lat;
        epoch_cyc();
        write_cyc(16'd21, 1'b1);
        write_cyc(16'd22, 1'b1);
        write_cyc(16'd23, 1'b1);
        bus.req_i = 1'b1;
        @(negedge clk);
        bus.req_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++; $display("FAIL abort_busy: got %b required 1", bus.busy_o);
        end
        epoch_cyc();
        checks++;
        if (bus.sel_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || int'(bus.count_o) !== 0) begin
            errors++;
            $display("FAIL abort_state: got sv=%b bz=%b cnt=%0d required 0 0 0",
                     bus.sel_valid_o, bus.busy_o, bus.count_o);
        end
        seen = 1'b0;
        for (int i = 0; i < int'(D) + 2; i++) begin
            if (bus.sel_valid_o) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_no_sel: got a sel_valid pulse required none");
        end
        bus.epoch_start_i = 1'b1;
        bus.wr_en_i       = 1'b1;
        bus.unsat_i       = 1'b1;
        bus.clause_id_i   = 16'd77;
        model_epoch();
        model_write(16'd77, 1'b1);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (int'(bus.count_o) !== 1) begin
            errors++; $display("FAIL epoch_write: got cnt=%0d required 1", bus.count_o);
        end
`ifndef SELECTOR_RANDOM_EN
        model_pick(1, exp_id, exp_lat);
`else
        exp_id  = 16'd77;
        exp_lat = 0;
`endif
        do_req(1'b0, got, allsat, id, lat, busy1, pa);
        checks++;
        if (!got || id !== 16'd77 || lat > int'(D) + 1 || (exp_lat != 0 && lat != exp_lat)) begin
            errors++;
            $display("FAIL epoch_write_sel: got v=%b id=%0d lat=%0d required id=%0d lat=%0d",
                     got, id, lat, exp_id, exp_lat);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        epoch_cyc();
        write_cyc(16'd31, 1'b1);
        write_cyc(16'd32, 1'b1);
        write_cyc(16'd33, 1'b1);
        bus.req_i = 1'b1;
        @(negedge clk);
        bus.req_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sel_valid_o, bus.busy_o, bus.all_sat_o, bus.overflow_o} !== 4'b0 ||
            bus.sel_clause_id_o !== '0 || int'(bus.count_o) !== 0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got sv=%b bz=%b cnt=%0d id=%0d required all 0",
                     bus.sel_valid_o, bus.busy_o, bus.count_o, bus.sel_clause_id_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_epoch();
        m_rr = 0;
        seen = 1'b0;
        for (int i = 0; i < int'(D) + 2; i++) begin
            @(negedge clk);
            if (bus.sel_valid_o || bus.busy_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL reset_mid_quiet: got activity after reset required none");
        end
    endtask

`ifndef SELECTOR_RANDOM_EN
    task automatic test_random_traffic();
        bit got, allsat, busy1, pa;
        logic [W-1:0] id, exp_id;
        int lat, exp_lat, snap, op;
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 19);
            if (op == 0) begin
                bus.epoch_start_i = 1'b1;
                model_epoch();
                drive_rand_write();
                @(negedge clk);
                idle_inputs();
            end else if (op < 10) begin
                write_cyc(W'($urandom()), ($urandom_range(0, 3) != 0));
            end else begin
                snap = m_mem.size();
                exp_id  = '0;
                exp_lat = 1;
                if (snap > 0) model_pick(snap, exp_id, exp_lat);
                do_req(1'b1, got, allsat, id, lat, busy1, pa);
                checks++;
                if (got != (snap > 0) || allsat != (snap == 0) || lat != exp_lat ||
                    (snap > 0 && id !== exp_id) || pa) begin
                    errors++;
                    $display("FAIL rand_req%0d: got v=%b as=%b id=%0d lat=%0d required v=%b id=%0d lat=%0d",
                             it, got, allsat, id, lat, snap > 0, exp_id, exp_lat);
                end
            end
            checks++;
            if (int'(bus.count_o) !== m_mem.size() || bus.overflow_o !== m_ovf) begin
                errors++;
                $display("FAIL rand_state%0d: got cnt=%0d ov=%b required cnt=%0d ov=%b",
                         it, bus.count_o, bus.overflow_o, m_mem.size(), m_ovf);
            end
        end
    endtask
`else
    task automatic test_random_sel();
        int hits[5];
        int hit_idx;
        bit got, allsat, busy1, pa;
        logic [W-1:0] id;
        int lat;
        hits = '{0, 0, 0, 0, 0};
        for (int it = 0; it < 1000; it++) begin
            if (m_mem.size() != 5) begin
                epoch_cyc();
                for (int j = 0; j < 5; j++) write_cyc(W'(100 + 7 * j), 1'b1);
            end
            do_req(1'b1, got, allsat, id, lat, busy1, pa);
            hit_idx = -1;
            for (int j = 0; j < 5; j++) if (m_mem[j] === id) hit_idx = j;
            checks++;
            if (!got || hit_idx < 0 || lat < 2 || lat > int'(D) + 1 || pa) begin
                errors++;
                $display("FAIL rsel%0d: got v=%b id=%0d lat=%0d required one of first 5 ids lat 2..%0d",
                         it, got, id, lat, D + 1);
            end else begin
                hits[hit_idx]++;
            end
            checks++;
            if (int'(bus.count_o) !== m_mem.size() || bus.overflow_o !== m_ovf) begin
                errors++;
                $display("FAIL rsel_state%0d: got cnt=%0d ov=%b required cnt=%0d ov=%b",
                         it, bus.count_o, bus.overflow_o, m_mem.size(), m_ovf);
            end
        end
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (hits[j] < 50) begin
                errors++;
                $display("FAIL rsel_spread%0d: got %0d hits required at least 50", j, hits[j]);
            end
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
`ifndef SELECTOR_RANDOM_EN
        test_round_robin();
`endif
        test_empty();
        test_overflow();
        test_abort();
        test_reset_mid();
`ifndef SELECTOR_RANDOM_EN
        test_random_traffic();
`else
        test_random_sel();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
